// File: rtl/imm_pixel_scanner.sv
// Raster-order frame-buffer scanner: reads one pixel per READ/CAPT pair and
// presents it with its (column,row) coordinates on a valid/ready output port.
module imm_pixel_scanner #(
   parameter int IMG_W = 320,
   parameter int IMG_H = 240
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [16:0] mem_addr,
   output logic        mem_en,
   input  logic [11:0] mem_rdata,
   output logic [11:0] pixel,
   output logic [8:0]  i_p,
   output logic [7:0]  j_p,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_CAPT = 3'd2,
      S_HOLD = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   localparam logic [8:0] COL_LAST = 9'(IMG_W - 1);
   localparam logic [7:0] ROW_LAST = 8'(IMG_H - 1);

   state_t      r_state;
   logic [8:0]  r_col;
   logic [7:0]  r_row;
   logic [16:0] r_addr;
   logic        r_mem_en;
   logic [11:0] r_pixel;
   logic [8:0]  r_i_p;
   logic [7:0]  r_j_p;
   logic        r_out_valid;
   logic        r_busy;
   logic        r_done;

   logic w_xfer;
   logic w_last_col;
   logic w_last_row;

   // Handshake: a pixel moves on a rising edge where out_valid and out_ready
   // are both 1; out_valid never drops and pixel/i_p/j_p never change before that.
   assign w_xfer     = (r_state == S_HOLD) && r_out_valid && out_ready;
   assign w_last_col = (r_col == COL_LAST);
   assign w_last_row = (r_row == ROW_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_col       <= '0;
         r_row       <= '0;
         r_addr      <= '0;
         r_mem_en    <= 1'b0;
         r_pixel     <= '0;
         r_i_p       <= '0;
         r_j_p       <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_mem_en <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_col    <= '0;
                  r_row    <= '0;
                  r_addr   <= '0;
                  r_mem_en <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= S_READ;
               end
            end
            S_READ: begin
               r_state <= S_CAPT;
            end
            S_CAPT: begin
               r_pixel     <= mem_rdata;
               r_i_p       <= r_col;
               r_j_p       <= r_row;
               r_out_valid <= 1'b1;
               r_state     <= S_HOLD;
            end
            S_HOLD: begin
               if (w_xfer) begin
                  r_out_valid <= 1'b0;
                  if (w_last_col && w_last_row) begin
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     // Address runs alongside col/row, so no multiply is needed.
                     r_addr   <= r_addr + 17'd1;
                     r_mem_en <= 1'b1;
                     r_state  <= S_READ;
                     if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + 8'd1;
                     end else begin
                        r_col <= r_col + 9'd1;
                     end
                  end
               end
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_addr  = r_addr;
   assign mem_en    = r_mem_en;
   assign pixel     = r_pixel;
   assign i_p       = r_i_p;
   assign j_p       = r_j_p;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign done      = r_done;
   assign dbg_state = r_state;

endmodule

// File: doc/imm_pixel_scanner.md
IMM_PIXEL_SCANNER -- requirements
Module: imm_pixel_scanner

Interface
REQ-001 Parameter IMG_W, default 320, image width in pixels (column count, range 1..512).
REQ-002 Parameter IMG_H, default 240, image height in pixels (row count, range 1..256).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  begin one full-frame scan; sampled only in IDLE.
REQ-006 mem_addr  output  17  frame-buffer read address, raster order, j*IMG_W+i.
REQ-007 mem_en  output  1  frame-buffer read enable; the memory returns mem_rdata exactly one cycle after mem_en=1.
REQ-008 mem_rdata  input  12  frame-buffer read data, 12-bit pixel.
REQ-009 pixel  output  12  registered pixel for the masking stage.
REQ-010 i_p  output  9  registered column coordinate of pixel.
REQ-011 j_p  output  8  registered row coordinate of pixel.
REQ-012 out_valid  output  1  pixel/i_p/j_p hold a valid pixel.
REQ-013 out_ready  input  1  masking stage accepts the pixel.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-016 FSM states are IDLE, READ, CAPT, HOLD and FIN, each encoded in a single state register.
REQ-017 IDLE: when start=1, clear the column/row counters to 0 and go to READ; otherwise stay in IDLE.
REQ-018 READ: mem_en=1 for this cycle only, mem_addr = row*IMG_W + col, next state CAPT.
REQ-019 CAPT: load pixel<=mem_rdata, i_p<=col and j_p<=row; set out_valid=1 on the next edge; next state HOLD.
REQ-020 HOLD: out_valid=1 and pixel/i_p/j_p stay stable until the transfer (out_valid & out_ready) is sampled.
REQ-021 Transfer at a non-final pixel: increment col, or wrap col to 0 and increment row when col=IMG_W-1; clear out_valid; go to READ.
REQ-022 Transfer at col=IMG_W-1, row=IMG_H-1: clear out_valid and go to FIN.
REQ-023 FIN: done=1 for exactly one cycle, then go to IDLE.
REQ-024 Per-pixel latency: a transfer occurs no earlier than 3 cycles after READ is entered, and READ is re-entered on the cycle after the transfer.
REQ-025 Full-speed throughput with out_ready tied high is one pixel per 3 cycles.
REQ-026 mem_addr is 17 bits, unsigned, with no overflow for the maximum parameters.
REQ-027 mem_addr is maintained as a running counter (+1 per pixel) and is not computed with a multiplier.
REQ-028 start is ignored while busy=1.
REQ-029 out_ready is ignored while out_valid=0.
REQ-030 A stall on out_ready of any length does not alter the held outputs and issues no memory read.
REQ-031 For IMG_W=1 or IMG_H=1, the scanner scans correctly with the wrap rules unchanged.
REQ-032 start=1 in the same cycle that FIN is active is ignored; a new scan requires start=1 while in IDLE.

Reset
REQ-033 While rst_n=0, state=IDLE and all of pixel, i_p, j_p, mem_addr, mem_en, out_valid, busy and done are 0, independent of clk.
REQ-034 Reset asserted mid-scan aborts the scan immediately with no done pulse; after release a new start is required.
REQ-035 The first active edge after rst_n deasserts may accept start.

Verification
REQ-036 IMG_W=4, IMG_H=3, out_ready=1, pulse start -> 12 transfers with (i_p,j_p) in order (0,0),(1,0)..(3,2) and mem_addr 0..11; transfers 3 cycles apart; done pulses once, 1 cycle after the last transfer.
REQ-037 Memory model returns data=addr+0x100; hold out_ready=0 for 5 cycles at pixel 2 -> pixel=0x102, i_p=2, j_p=0 stable for all 5 cycles; mem_en stays 0 during the stall.
REQ-038 Row wrap: at (3,0) accepted -> next READ has mem_addr=4 and the next transfer has i_p=0, j_p=1.
REQ-039 start pulsed again while busy at pixel 5 -> no effect; scan completes with exactly 12 transfers.
REQ-040 rst_n=0 asynchronously at pixel 7, between clock edges -> all outputs are 0 immediately; no done pulse; after release and start, the scan restarts at (0,0), addr 0.
REQ-041 IMG_W=320, IMG_H=240 default scan -> final transfer has i_p=319, j_p=239, mem_addr=76799; total transfers = 76800.
